zeus_io_controller: RTL and testbench

Parametrised input/output unit for the Zeus processor. It replaces the gated-clock input wait with a stall handshake on the free-running system clock. It debounces the confirm button and selects one of N_IN switch channels for a read. It latches print data into one of N_OUT output registers.
It sits between the control unit (ler_da_entrada, print_out), the register file (Rs) and the board I/O.

---
 rtl/zeus_io_controller_if.sv | 53 +++++
 rtl/zeus_io_controller.sv | 170 +++++++++++++++++
 tb/tb_zeus_io_controller.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/zeus_io_controller_if.sv
// -----------------------------------------------------------------------------
// zeus_io_controller_if
// Bundles the control-unit / register-file / board-side signals of the Zeus
// I/O controller.
//   slave  modport : the controller (drives stall, read data, print registers)
//   master modport : the surrounding processor and board (drives requests)
// Signals:
//   confirma_bt     raw confirm button (asynchronous, active high)
//   entrada         N_IN switch channels, channel k at [k*IN_W +: IN_W]
//   ler_da_entrada  read request level from the control unit
//   in_sel          input channel select
//   stall           hold PC / register-file write
//   entrada_valida  one-cycle read-complete pulse
//   entrada_lida    extended captured input value
//   print_out       print request (one cycle per instruction)
//   out_sel         output channel select
//   print_dados_in  value to print (Rs)
//   print_dados     N_OUT output registers, channel k at [k*DATA_W +: DATA_W]
//   print_valid     per-channel one-cycle write pulse
// -----------------------------------------------------------------------------
interface zeus_io_controller_if #(
    parameter int DATA_W = 32,
    parameter int IN_W   = 16,
    parameter int N_IN   = 2,
    parameter int N_OUT  = 2,
    parameter int SEL_W  = (((N_IN > N_OUT) ? N_IN : N_OUT) > 1)
                           ? $clog2((N_IN > N_OUT) ? N_IN : N_OUT) : 1
);
    logic                    confirma_bt;
    logic [N_IN*IN_W-1:0]    entrada;
    logic                    ler_da_entrada;
    logic [SEL_W-1:0]        in_sel;
    logic                    stall;
    logic                    entrada_valida;
    logic [DATA_W-1:0]       entrada_lida;
    logic                    print_out;
    logic [SEL_W-1:0]        out_sel;
    logic [DATA_W-1:0]       print_dados_in;
    logic [N_OUT*DATA_W-1:0] print_dados;
    logic [N_OUT-1:0]        print_valid;

    modport slave (
        input  confirma_bt, entrada, ler_da_entrada, in_sel,
               print_out, out_sel, print_dados_in,
        output stall, entrada_valida, entrada_lida, print_dados, print_valid
    );

    modport master (
        output confirma_bt, entrada, ler_da_entrada, in_sel,
               print_out, out_sel, print_dados_in,
        input  stall, entrada_valida, entrada_lida, print_dados, print_valid
    );
endinterface

// File: rtl/zeus_io_controller.sv
// -----------------------------------------------------------------------------
// zeus_io_controller
// Input/output unit for the Zeus processor, on the free-running system clock.
//   Input:  a read request stalls the core until a debounced rising edge of the
//           confirm button, then captures the selected switch channel
//           (sign- or zero-extended) and pulses entrada_valida for one cycle.
//           The FSM waits for button release before accepting another read, so
//           one press never completes two reads.
//   Output: a print request writes print_dados_in into the selected output
//           register and pulses that channel's print_valid bit for one cycle.
// Ports:
//   clock    system clock, rising edge
//   reset_n  synchronous reset, active low
//   io       zeus_io_controller_if.slave (see interface header)
// -----------------------------------------------------------------------------
module zeus_io_controller #(
    parameter int DATA_W          = 32,
    parameter int IN_W            = 16,
    parameter int N_IN            = 2,
    parameter int N_OUT           = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SIGN_EXT        = 1,
    parameter int SEL_W           = (((N_IN > N_OUT) ? N_IN : N_OUT) > 1)
                                    ? $clog2((N_IN > N_OUT) ? N_IN : N_OUT) : 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    zeus_io_controller_if.slave  io
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        DONE,
        WAIT_RELEASE
    } state_e;

    state_e                  state_q, state_d;
    logic                    sync1_q, sync1_d;
    logic                    sync2_q, sync2_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    deb_q, deb_d;
    logic                    deb_dly_q, deb_dly_d;
    logic [DATA_W-1:0]       lida_q, lida_d;
    logic [N_OUT*DATA_W-1:0] print_dados_q, print_dados_d;
    logic [N_OUT-1:0]        print_valid_q, print_valid_d;

    logic                    btn_s;
    logic                    rise;
    logic [IN_W-1:0]         in_ch;
    logic [DATA_W-1:0]       in_ext;

    // Button path: 2-FF synchroniser, then a counter that must see the new
    // level on DEBOUNCE_CYCLES consecutive edges before deb follows it.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first so that no path leaves it unassigned and infers a latch.
        sync1_d   = io.confirma_bt;
        sync2_d   = sync1_q;
        btn_s     = sync2_q;
        deb_d     = deb_q;
        deb_dly_d = deb_q;
        cnt_d     = '0;
        if (btn_s != deb_q) begin
            if (cnt_q == CNT_MAX) begin
                deb_d = btn_s;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        rise = deb_q & ~deb_dly_q;
    end

    // Channel select and extension; an out-of-range in_sel leaves in_ch at 0.
    always_comb begin
        in_ch = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (io.in_sel == SEL_W'(k)) begin
                in_ch = io.entrada[k*IN_W +: IN_W];
            end
        end
        in_ext = '0;
        in_ext[IN_W-1:0] = in_ch;
        if (SIGN_EXT != 0 && in_ch[IN_W-1]) begin
            for (int i = IN_W; i < DATA_W; i++) begin
                in_ext[i] = 1'b1;
            end
        end
    end

    // Read FSM: next state and capture register.
    always_comb begin
        state_d = state_q;
        lida_d  = lida_q;
        unique case (state_q)
            IDLE: begin
                if (io.ler_da_entrada) begin
                    state_d = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                // A withdrawn request wins over a coincident press.
                if (!io.ler_da_entrada) begin
                    state_d = IDLE;
                end else if (rise) begin
                    lida_d  = in_ext;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                if (!deb_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Print path: independent of the FSM, honoured even while stalled.
    always_comb begin
        print_dados_d = print_dados_q;
        print_valid_d = '0;
        for (int k = 0; k < N_OUT; k++) begin
            if (io.print_out && io.out_sel == SEL_W'(k)) begin
                print_dados_d[k*DATA_W +: DATA_W] = io.print_dados_in;
                print_valid_d[k]                  = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            cnt_q         <= '0;
            deb_q         <= 1'b0;
            deb_dly_q     <= 1'b0;
            lida_q        <= '0;
            // NOTE: the output register bank is reset like any other flop
            // because its contents drive board outputs directly.
            print_dados_q <= '0;
            print_valid_q <= '0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            cnt_q         <= cnt_d;
            deb_q         <= deb_d;
            deb_dly_q     <= deb_dly_d;
            lida_q        <= lida_d;
            print_dados_q <= print_dados_d;
            print_valid_q <= print_valid_d;
        end
    end

    // Stall is combinational so a new request stalls in its very first cycle.
    assign io.stall          = io.ler_da_entrada & (state_q != DONE);
    assign io.entrada_valida = (state_q == DONE);
    assign io.entrada_lida   = lida_q;
    assign io.print_dados    = print_dados_q;
    assign io.print_valid    = print_valid_q;
endmodule

// File: tb/tb_zeus_io_controller.sv
// -----------------------------------------------------------------------------
// tb_zeus_io_controller
// Directed bench for zeus_io_controller. Two instances share one stimulus:
// dut0 sign-extends, dut1 zero-extends. SEL_W is widened to 2 so that
// out-of-range channel selects can be driven. Inputs change and outputs are
// sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_zeus_io_controller;
    localparam int DATA_W = 32;
    localparam int IN_W   = 16;
    localparam int N_IN   = 2;
    localparam int N_OUT  = 2;
    localparam int SEL_W  = 2;
    localparam int MAX_WAIT = 20;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        bt, ler, print_out;
    logic [31:0] entrada;
    logic [31:0] pdin;
    logic [1:0]  in_sel, out_sel;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    zeus_io_controller_if #(.DATA_W(DATA_W), .IN_W(IN_W), .N_IN(N_IN),
                            .N_OUT(N_OUT), .SEL_W(SEL_W)) io0 ();
    zeus_io_controller_if #(.DATA_W(DATA_W), .IN_W(IN_W), .N_IN(N_IN),
                            .N_OUT(N_OUT), .SEL_W(SEL_W)) io1 ();

    assign io0.confirma_bt    = bt;
    assign io0.entrada        = entrada;
    assign io0.ler_da_entrada = ler;
    assign io0.in_sel         = in_sel;
    assign io0.print_out      = print_out;
    assign io0.out_sel        = out_sel;
    assign io0.print_dados_in = pdin;
    assign io1.confirma_bt    = bt;
    assign io1.entrada        = entrada;
    assign io1.ler_da_entrada = ler;
    assign io1.in_sel         = in_sel;
    assign io1.print_out      = print_out;
    assign io1.out_sel        = out_sel;
    assign io1.print_dados_in = pdin;

    zeus_io_controller #(.DATA_W(DATA_W), .IN_W(IN_W), .N_IN(N_IN), .N_OUT(N_OUT),
                         .DEBOUNCE_CYCLES(4), .SIGN_EXT(1), .SEL_W(SEL_W)) dut0 (
        .clock   (clock),
        .reset_n (reset_n),
        .io      (io0)
    );

    zeus_io_controller #(.DATA_W(DATA_W), .IN_W(IN_W), .N_IN(N_IN), .N_OUT(N_OUT),
                         .DEBOUNCE_CYCLES(4), .SIGN_EXT(0), .SEL_W(SEL_W)) dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .io      (io1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Presses the button and expects the valid pulse 7 cycles later with stall
    // high until then, low in the valid cycle, and a one-cycle pulse.
    task automatic press_and_wait(input string tag, input logic [31:0] exp0,
                                  input logic [31:0] exp1);
        int   lat;
        logic stall_bad;
        lat       = 0;
        stall_bad = 1'b0;
        bt        = 1'b1;
        for (int n = 1; n <= MAX_WAIT; n++) begin
            @(negedge clock);
            if (io0.entrada_valida) begin
                lat = n;
                break;
            end
            if (!io0.stall) stall_bad = 1'b1;
        end
        check({tag, "_latency"}, 64'(lat), 64'd7);
        check({tag, "_stall_wait"}, 64'(stall_bad), 64'd0);
        check({tag, "_stall_valid"}, 64'(io0.stall), 64'd0);
        check({tag, "_valid_zext"}, 64'(io1.entrada_valida), 64'd1);
        check({tag, "_data_sext"}, 64'(io0.entrada_lida), 64'(exp0));
        check({tag, "_data_zext"}, 64'(io1.entrada_lida), 64'(exp1));
        @(negedge clock);
        check({tag, "_pulse_end"}, 64'(io0.entrada_valida), 64'd0);
    endtask

    // Watches n cycles: no valid pulse, stall constant at exp_stall.
    task automatic observe_quiet(input string tag, input int n, input logic exp_stall);
        int pulses;
        int stall_bad;
        pulses    = 0;
        stall_bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (io0.entrada_valida) pulses++;
            if (io0.stall !== exp_stall) stall_bad++;
        end
        check({tag, "_pulses"}, 64'(pulses), 64'd0);
        check({tag, "_stall"}, 64'(stall_bad), 64'd0);
    endtask

    initial begin
        bt        = 1'b0;
        ler       = 1'b0;
        print_out = 1'b0;
        entrada   = '0;
        pdin      = '0;
        in_sel    = '0;
        out_sel   = '0;
        reset_n   = 1'b0;
        cycles(3);
        check("rst_lida", 64'(io0.entrada_lida), 64'd0);
        check("rst_dados", 64'(io0.print_dados), 64'd0);
        check("rst_pvalid", 64'(io0.print_valid), 64'd0);
        check("rst_valid", 64'(io0.entrada_valida), 64'd0);
        check("rst_stall", 64'(io0.stall), 64'd0);
        reset_n = 1'b1;
        cycles(1);

        // 1/2: sign- and zero-extended read of channel 1.
        entrada = {16'h8001, 16'h1234};
        in_sel  = 2'd1;
        ler     = 1'b1;
        #1;
        check("t1_stall_entry", 64'(io0.stall), 64'd1);
        press_and_wait("t1", 32'hFFFF8001, 32'h00008001);
        ler = 1'b0;
        #1;
        check("t1_stall_noreq", 64'(io0.stall), 64'd0);
        bt = 1'b0;
        cycles(10);

        // 3: 3-cycle glitch ignored, then a 10-cycle press completes.
        entrada = {16'h8001, 16'h0042};
        in_sel  = 2'd0;
        ler     = 1'b1;
        bt      = 1'b1;
        cycles(3);
        bt = 1'b0;
        observe_quiet("t3_glitch", 12, 1'b1);
        press_and_wait("t3", 32'h00000042, 32'h00000042);
        cycles(2);
        bt  = 1'b0;
        ler = 1'b0;
        cycles(10);

        // 4: back-to-back reads with the button held across both requests.
        entrada = {16'h7FFF, 16'h0000};
        in_sel  = 2'd1;
        ler     = 1'b1;
        press_and_wait("t4a", 32'h00007FFF, 32'h00007FFF);
        entrada = {16'h0005, 16'h0000};
        observe_quiet("t4_held", 15, 1'b1);
        bt = 1'b0;
        observe_quiet("t4_release", 10, 1'b1);
        press_and_wait("t4b", 32'h00000005, 32'h00000005);
        ler = 1'b0;
        bt  = 1'b0;
        cycles(10);

        // 5: output registers.
        out_sel   = 2'd1;
        pdin      = 32'hDEADBEEF;
        print_out = 1'b1;
        cycles(1);
        print_out = 1'b0;
        check("t5_dados_ch1", 64'(io0.print_dados), 64'hDEADBEEF_00000000);
        check("t5_pvalid_ch1", 64'(io0.print_valid), 64'd2);
        cycles(1);
        check("t5_pvalid_end", 64'(io0.print_valid), 64'd0);
        out_sel   = 2'd3;
        pdin      = 32'h12345678;
        print_out = 1'b1;
        cycles(1);
        print_out = 1'b0;
        check("t5_dados_oor", 64'(io0.print_dados), 64'hDEADBEEF_00000000);
        check("t5_pvalid_oor", 64'(io0.print_valid), 64'd0);
        out_sel   = 2'd0;
        pdin      = 32'h0BADF00D;
        print_out = 1'b1;
        cycles(1);
        print_out = 1'b0;
        check("t5_dados_ch0", 64'(io0.print_dados), 64'hDEADBEEF_0BADF00D);
        check("t5_pvalid_ch0", 64'(io0.print_valid), 64'd1);

        // 6: print while stalled, then reset in the middle of WAIT_PRESS.
        entrada = {16'h8001, 16'h0000};
        in_sel  = 2'd1;
        ler     = 1'b1;
        bt      = 1'b1;
        cycles(4);
        out_sel   = 2'd1;
        pdin      = 32'hCAFEF00D;
        print_out = 1'b1;
        cycles(1);
        print_out = 1'b0;
        check("t6_stall_print", 64'(io0.stall), 64'd1);
        check("t6_dados_stalled", 64'(io0.print_dados), 64'hCAFEF00D_0BADF00D);
        check("t6_pvalid_stalled", 64'(io0.print_valid), 64'd2);
        reset_n = 1'b0;
        bt      = 1'b0;
        cycles(2);
        check("t6_rst_lida", 64'(io0.entrada_lida), 64'd0);
        check("t6_rst_dados", 64'(io0.print_dados), 64'd0);
        check("t6_rst_pvalid", 64'(io0.print_valid), 64'd0);
        check("t6_rst_valid", 64'(io0.entrada_valida), 64'd0);
        check("t6_rst_stall", 64'(io0.stall), 64'd1);
        reset_n = 1'b1;
        observe_quiet("t6_after_rst", 12, 1'b1);
        press_and_wait("t6", 32'hFFFF8001, 32'h00008001);
        ler = 1'b0;
        bt  = 1'b0;
        cycles(10);

        // Out-of-range input channel captures 0.
        in_sel = 2'd3;
        ler    = 1'b1;
        press_and_wait("t6_in_oor", 32'h00000000, 32'h00000000);
        ler = 1'b0;
        bt  = 1'b0;
        cycles(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
